// File: rtl/probe_monitor.sv
// probe_monitor: edge/pulse statistics for NDIG digital probe channels and
// min/max/count/sum tracking for one unsigned analog sample bus.
// All outputs are registers updated one cycle after the sampling edge.
module probe_monitor #(
  parameter int NDIG = 4,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int SW   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [NDIG-1:0]   i_dig,
  input  logic [DW-1:0]     i_ana,
  input  logic              i_ana_vld,
  output logic [NDIG-1:0]   o_rise,
  output logic [NDIG-1:0]   o_fall,
  output logic [NDIG*CW-1:0] o_rise_cnt,
  output logic [NDIG*CW-1:0] o_high_cnt,
  output logic [NDIG*CW-1:0] o_last_width,
  output logic [DW-1:0]     o_ana_last,
  output logic [DW-1:0]     o_ana_min,
  output logic [DW-1:0]     o_ana_max,
  output logic [CW-1:0]     o_ana_cnt,
  output logic [SW-1:0]     o_ana_sum
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Saturating increment shared by every CW-wide counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic [NDIG-1:0]    d_r;
  logic [NDIG-1:0]    rise_s;
  logic [NDIG-1:0]    fall_s;
  logic [NDIG*CW-1:0] wcnt_r;
  logic [NDIG*CW-1:0] wcnt_nxt_s;
  logic [NDIG*CW-1:0] rise_cnt_nxt_s;
  logic [NDIG*CW-1:0] high_cnt_nxt_s;
  logic [NDIG*CW-1:0] last_width_nxt_s;
  logic [SW:0]        sum_ext_s;
  logic [SW-1:0]      sum_nxt_s;
  logic [DW-1:0]      min_nxt_s;
  logic [DW-1:0]      max_nxt_s;

  // Per-channel edge detection and next values of the digital statistics.
  always_comb begin
    rise_s           = i_dig & ~d_r;
    fall_s           = ~i_dig & d_r;
    wcnt_nxt_s       = wcnt_r;
    rise_cnt_nxt_s   = o_rise_cnt;
    high_cnt_nxt_s   = o_high_cnt;
    last_width_nxt_s = o_last_width;
    for (int n = 0; n < NDIG; n++) begin
      if (rise_s[n]) begin
        rise_cnt_nxt_s[n*CW +: CW] = sat_inc(o_rise_cnt[n*CW +: CW]);
        wcnt_nxt_s[n*CW +: CW]     = CNT_ONE;
      end else if (i_dig[n] && d_r[n]) begin
        rise_cnt_nxt_s[n*CW +: CW] = o_rise_cnt[n*CW +: CW];
        wcnt_nxt_s[n*CW +: CW]     = sat_inc(wcnt_r[n*CW +: CW]);
      end else begin
        rise_cnt_nxt_s[n*CW +: CW] = o_rise_cnt[n*CW +: CW];
        wcnt_nxt_s[n*CW +: CW]     = wcnt_r[n*CW +: CW];
      end
      if (i_dig[n]) begin
        high_cnt_nxt_s[n*CW +: CW] = sat_inc(o_high_cnt[n*CW +: CW]);
      end else begin
        high_cnt_nxt_s[n*CW +: CW] = o_high_cnt[n*CW +: CW];
      end
      // A falling edge publishes the width of the pulse that just ended.
      if (fall_s[n]) begin
        last_width_nxt_s[n*CW +: CW] = wcnt_r[n*CW +: CW];
      end else begin
        last_width_nxt_s[n*CW +: CW] = o_last_width[n*CW +: CW];
      end
    end
  end

  // Next values of the analog tracking registers (used only when a sample is valid).
  always_comb begin
    sum_ext_s = {1'b0, o_ana_sum} + {{(SW+1-DW){1'b0}}, i_ana};
    if (sum_ext_s[SW]) begin
      sum_nxt_s = {SW{1'b1}};
    end else begin
      sum_nxt_s = sum_ext_s[SW-1:0];
    end
    if (i_ana < o_ana_min) begin
      min_nxt_s = i_ana;
    end else begin
      min_nxt_s = o_ana_min;
    end
    if (i_ana > o_ana_max) begin
      max_nxt_s = i_ana;
    end else begin
      max_nxt_s = o_ana_max;
    end
  end

  // State register: reset clears everything, clear wipes statistics but keeps sampling.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d_r          <= {NDIG{1'b0}};
      o_rise       <= {NDIG{1'b0}};
      o_fall       <= {NDIG{1'b0}};
      wcnt_r       <= {(NDIG*CW){1'b0}};
      o_rise_cnt   <= {(NDIG*CW){1'b0}};
      o_high_cnt   <= {(NDIG*CW){1'b0}};
      o_last_width <= {(NDIG*CW){1'b0}};
      o_ana_last   <= {DW{1'b0}};
      o_ana_min    <= {DW{1'b1}};
      o_ana_max    <= {DW{1'b0}};
      o_ana_cnt    <= {CW{1'b0}};
      o_ana_sum    <= {SW{1'b0}};
    end else begin
      d_r <= i_dig;
      if (i_clr) begin
        o_rise       <= {NDIG{1'b0}};
        o_fall       <= {NDIG{1'b0}};
        wcnt_r       <= {(NDIG*CW){1'b0}};
        o_rise_cnt   <= {(NDIG*CW){1'b0}};
        o_high_cnt   <= {(NDIG*CW){1'b0}};
        o_last_width <= {(NDIG*CW){1'b0}};
        o_ana_last   <= {DW{1'b0}};
        o_ana_min    <= {DW{1'b1}};
        o_ana_max    <= {DW{1'b0}};
        o_ana_cnt    <= {CW{1'b0}};
        o_ana_sum    <= {SW{1'b0}};
      end else begin
        o_rise       <= rise_s;
        o_fall       <= fall_s;
        wcnt_r       <= wcnt_nxt_s;
        o_rise_cnt   <= rise_cnt_nxt_s;
        o_high_cnt   <= high_cnt_nxt_s;
        o_last_width <= last_width_nxt_s;
        if (i_ana_vld) begin
          o_ana_last <= i_ana;
          o_ana_min  <= min_nxt_s;
          o_ana_max  <= max_nxt_s;
          o_ana_cnt  <= sat_inc(o_ana_cnt);
          o_ana_sum  <= sum_nxt_s;
        end else begin
          o_ana_last <= o_ana_last;
          o_ana_min  <= o_ana_min;
          o_ana_max  <= o_ana_max;
          o_ana_cnt  <= o_ana_cnt;
          o_ana_sum  <= o_ana_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_probe_monitor.sv
// tb_probe_monitor: directed vectors with hand-computed expectations for
// probe_monitor; a second instance with CW=4 exercises counter saturation.
module tb_probe_monitor;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [3:0]  dig;
  logic [15:0] ana;
  logic        ana_vld;

  logic [3:0]  rise, fall;
  logic [63:0] rise_cnt, high_cnt, last_width;
  logic [15:0] ana_last, ana_min, ana_max, ana_cnt;
  logic [31:0] ana_sum;

  logic [3:0]  rise4, fall4;
  logic [15:0] rise_cnt4, high_cnt4, last_width4;
  logic [15:0] ana_last4, ana_min4, ana_max4;
  logic [3:0]  ana_cnt4;
  logic [31:0] ana_sum4;

  int n_vec = 0;
  int n_err = 0;

  probe_monitor #(.NDIG(4), .DW(16), .CW(16), .SW(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_dig(dig), .i_ana(ana),
    .i_ana_vld(ana_vld), .o_rise(rise), .o_fall(fall), .o_rise_cnt(rise_cnt),
    .o_high_cnt(high_cnt), .o_last_width(last_width), .o_ana_last(ana_last),
    .o_ana_min(ana_min), .o_ana_max(ana_max), .o_ana_cnt(ana_cnt),
    .o_ana_sum(ana_sum)
  );

  probe_monitor #(.NDIG(4), .DW(16), .CW(4), .SW(32)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_dig(dig), .i_ana(ana),
    .i_ana_vld(ana_vld), .o_rise(rise4), .o_fall(fall4), .o_rise_cnt(rise_cnt4),
    .o_high_cnt(high_cnt4), .o_last_width(last_width4), .o_ana_last(ana_last4),
    .o_ana_min(ana_min4), .o_ana_max(ana_max4), .o_ana_cnt(ana_cnt4),
    .o_ana_sum(ana_sum4)
  );

  // Free-running 10 ns probe clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count it.
  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; dig = 4'h0; ana = 16'h0000; ana_vld = 1'b0;
    tick(2);
    chk_val("rst_rise_cnt", rise_cnt, 64'h0);
    chk_val("rst_last_width", last_width, 64'h0);
    chk_val("rst_ana_min", ana_min, 64'hFFFF);
    chk_val("rst_ana_sum", ana_sum, 64'h0);
    rst = 1'b0;
    tick();

    // 1: channel 0 high for three cycles
    dig[0] = 1'b1; tick();
    chk_val("t1_rise", rise, 64'h1);
    chk_val("t1_rise_cnt0", rise_cnt[15:0], 64'd1);
    tick();
    chk_val("t1_rise_off", rise, 64'h0);
    tick();
    chk_val("t1_high_cnt0_pre", high_cnt[15:0], 64'd3);
    chk_val("t1_width_pending", last_width[15:0], 64'd0);
    dig[0] = 1'b0; tick();
    chk_val("t1_fall", fall, 64'h1);
    chk_val("t1_last_width0", last_width[15:0], 64'd3);
    chk_val("t1_high_cnt0", high_cnt[15:0], 64'd3);
    tick();
    chk_val("t1_fall_off", fall, 64'h0);

    // 2: channel 1 five one-cycle glitches separated by two low cycles
    for (int p = 0; p < 5; p++) begin
      dig[1] = 1'b1; tick();
      dig[1] = 1'b0; tick(2);
    end
    chk_val("t2_rise_cnt1", rise_cnt[31:16], 64'd5);
    chk_val("t2_last_width1", last_width[31:16], 64'd1);
    chk_val("t2_high_cnt1", high_cnt[31:16], 64'd5);
    chk_val("t2_rise_cnt23", rise_cnt[63:32], 64'h0);
    chk_val("t2_high_cnt23", high_cnt[63:32], 64'h0);
    chk_val("t2_rise_cnt0", rise_cnt[15:0], 64'd1);

    // 3: channel 2 high for 20 cycles; CW=4 instance saturates at 15
    dig[2] = 1'b1; tick(20);
    chk_val("t3_high_cnt2_cw4", high_cnt4[11:8], 64'd15);
    chk_val("t3_high_cnt2_cw16", high_cnt[47:32], 64'd20);
    dig[2] = 1'b0; tick();
    chk_val("t3_last_width2_cw4", last_width4[11:8], 64'd15);
    chk_val("t3_last_width2_cw16", last_width[47:32], 64'd20);
    chk_val("t3_fall4", fall4, 64'h4);

    // 4: analog samples, one of them not qualified
    ana = 16'h0100; ana_vld = 1'b1; tick();
    chk_val("t4_min_first", ana_min, 64'h0100);
    ana = 16'h0040; tick();
    ana = 16'h0FFF; ana_vld = 1'b0; tick();
    chk_val("t4_hold_last", ana_last, 64'h0040);
    ana = 16'h0200; ana_vld = 1'b1; tick();
    ana_vld = 1'b0; tick();
    chk_val("t4_last", ana_last, 64'h0200);
    chk_val("t4_min", ana_min, 64'h0040);
    chk_val("t4_max", ana_max, 64'h0200);
    chk_val("t4_cnt", ana_cnt, 64'd3);
    chk_val("t4_sum", ana_sum, 64'h0340);
    // equal sample leaves min unchanged, still counts
    ana = 16'h0040; ana_vld = 1'b1; tick();
    ana_vld = 1'b0;
    chk_val("t4_min_equal", ana_min, 64'h0040);
    chk_val("t4_sum_equal", ana_sum, 64'h0380);

    // 5: clear coincident with a rise on channel 0 and a valid sample
    dig[0] = 1'b1; clr = 1'b1; ana = 16'h0123; ana_vld = 1'b1; tick();
    chk_val("t5_rise", rise, 64'h0);
    chk_val("t5_rise_cnt", rise_cnt, 64'h0);
    chk_val("t5_high_cnt", high_cnt, 64'h0);
    chk_val("t5_last_width", last_width, 64'h0);
    chk_val("t5_ana_min", ana_min, 64'hFFFF);
    chk_val("t5_ana_cnt", ana_cnt, 64'h0);
    chk_val("t5_ana_sum", ana_sum, 64'h0);
    chk_val("t5_ana_last", ana_last, 64'h0);
    clr = 1'b0; ana_vld = 1'b0; tick();
    chk_val("t5_no_late_rise", rise, 64'h0);
    tick();
    chk_val("t5_high_cnt0", high_cnt[15:0], 64'd2);
    dig[0] = 1'b0; tick();
    chk_val("t5_fall", fall, 64'h1);
    chk_val("t5_last_width0", last_width[15:0], 64'd2);
    chk_val("t5_rise_cnt0", rise_cnt[15:0], 64'd0);

    // 6: reset in the middle of a channel 3 pulse held through release
    dig[3] = 1'b1; tick(3);
    rst = 1'b1; tick(2);
    chk_val("t6_rst_width3", last_width[63:48], 64'd0);
    chk_val("t6_rst_high3", high_cnt[63:48], 64'd0);
    rst = 1'b0; tick();
    chk_val("t6_rise_after_rel", rise, 64'h8);
    chk_val("t6_rise_cnt3", rise_cnt[63:48], 64'd1);
    chk_val("t6_width3_zero", last_width[63:48], 64'd0);
    tick();
    chk_val("t6_rise_off", rise, 64'h0);
    dig[3] = 1'b0; tick();
    chk_val("t6_fall", fall, 64'h8);
    chk_val("t6_last_width3", last_width[63:48], 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
